// File: rtl/agu_addr_pipe.sv
// Two-stage AGU address pipeline: E1 captures issued ops, E2 holds the effective address
// and alignment result, and its contents are decoded to the SAQ, load port or exception report.
module agu_addr_pipe #(
    parameter int unsigned WIDTH = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_base,
    input  logic [31:0]       i_imm,
    input  logic [WIDTH-1:0]  i_tag,
    input  logic              i_store,
    input  logic [1:0]        i_size,
    input  logic              i_flush,
    output logic              o_saq_en,
    output logic [31:0]       o_saq_addr,
    output logic [WIDTH-1:0]  o_saq_tag,
    output logic              o_ld_valid,
    input  logic              i_ld_ready,
    output logic [31:0]       o_ld_addr,
    output logic [WIDTH-1:0]  o_ld_tag,
    output logic [1:0]        o_ld_size,
    output logic              o_exc_valid,
    output logic [WIDTH-1:0]  o_exc_tag,
    output logic [31:0]       o_exc_addr
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    logic              r_e1_v;
    logic [31:0]       r_e1_base;
    logic [31:0]       r_e1_imm;
    logic [WIDTH-1:0]  r_e1_tag;
    logic              r_e1_st;
    size_e             r_e1_size;

    logic              r_e2_v;
    logic [31:0]       r_e2_addr;
    logic [WIDTH-1:0]  r_e2_tag;
    logic              r_e2_st;
    size_e             r_e2_size;
    logic              r_e2_mis;

    logic [31:0]       w_sum;
    logic              w_mis;
    logic              w_e2_adv;
    logic              w_e1_load;

    // Carry out of the sum is dropped on purpose: address wrap is legal.
    always_comb begin
        w_sum = r_e1_base + r_e1_imm;
        w_mis = 1'b0;
        case (r_e1_size)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: w_mis = w_sum[0];
            SZ_WORD: w_mis = |w_sum[1:0];
            default: w_mis = 1'b1;
        endcase
    end

    // Only a pending, unaccepted load can hold E2; SAQ and exception paths always drain.
    assign w_e2_adv  = !r_e2_v || r_e2_st || r_e2_mis || i_ld_ready;
    assign w_e1_load = !r_e1_v || w_e2_adv;
    assign o_ready   = !i_flush && w_e1_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e1_v    <= 1'b0;
            r_e1_base <= '0;
            r_e1_imm  <= '0;
            r_e1_tag  <= '0;
            r_e1_st   <= 1'b0;
            r_e1_size <= SZ_BYTE;
        end else if (i_flush) begin
            r_e1_v <= 1'b0;
        end else if (w_e1_load) begin
            r_e1_v <= i_valid;
            if (i_valid) begin
                r_e1_base <= i_base;
                r_e1_imm  <= i_imm;
                r_e1_tag  <= i_tag;
                r_e1_st   <= i_store;
                r_e1_size <= size_e'(i_size);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e2_v    <= 1'b0;
            r_e2_addr <= '0;
            r_e2_tag  <= '0;
            r_e2_st   <= 1'b0;
            r_e2_size <= SZ_BYTE;
            r_e2_mis  <= 1'b0;
        end else if (i_flush) begin
            r_e2_v <= 1'b0;
        end else if (w_e2_adv) begin
            r_e2_v <= r_e1_v;
            if (r_e1_v) begin
                r_e2_addr <= w_sum;
                r_e2_tag  <= r_e1_tag;
                r_e2_st   <= r_e1_st;
                r_e2_size <= r_e1_size;
                r_e2_mis  <= w_mis;
            end
        end
    end

    assign o_saq_en    = r_e2_v &&  r_e2_st && !r_e2_mis;
    assign o_ld_valid  = r_e2_v && !r_e2_st && !r_e2_mis;
    assign o_exc_valid = r_e2_v &&  r_e2_mis;

    // Stale E2 data is masked so every field reads 0 while the stage is empty.
    assign o_saq_addr = r_e2_v ? r_e2_addr : '0;
    assign o_saq_tag  = r_e2_v ? r_e2_tag  : '0;
    assign o_ld_addr  = r_e2_v ? r_e2_addr : '0;
    assign o_ld_tag   = r_e2_v ? r_e2_tag  : '0;
    assign o_ld_size  = r_e2_v ? r_e2_size : '0;
    assign o_exc_addr = r_e2_v ? r_e2_addr : '0;
    assign o_exc_tag  = r_e2_v ? r_e2_tag  : '0;

endmodule

// File: tb/tb_agu_addr_pipe.sv
// Scoreboard bench for agu_addr_pipe: issued ops push their expected routing/address,
// a negedge monitor pops and compares each SAQ write, accepted load and exception pulse.
module tb_agu_addr_pipe;

    localparam int unsigned W = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_base;
    logic [31:0]   i_imm;
    logic [W-1:0]  i_tag;
    logic          i_store;
    logic [1:0]    i_size;
    logic          i_flush;
    logic          o_saq_en;
    logic [31:0]   o_saq_addr;
    logic [W-1:0]  o_saq_tag;
    logic          o_ld_valid;
    logic          i_ld_ready;
    logic [31:0]   o_ld_addr;
    logic [W-1:0]  o_ld_tag;
    logic [1:0]    o_ld_size;
    logic          o_exc_valid;
    logic [W-1:0]  o_exc_tag;
    logic [31:0]   o_exc_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           kind;   // 0 SAQ, 1 load, 2 exception
        logic [31:0]  addr;
        logic [W-1:0] tag;
        logic [1:0]   size;
    } exp_t;

    exp_t sb[$];

    agu_addr_pipe #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_base      (i_base),
        .i_imm       (i_imm),
        .i_tag       (i_tag),
        .i_store     (i_store),
        .i_size      (i_size),
        .i_flush     (i_flush),
        .o_saq_en    (o_saq_en),
        .o_saq_addr  (o_saq_addr),
        .o_saq_tag   (o_saq_tag),
        .o_ld_valid  (o_ld_valid),
        .i_ld_ready  (i_ld_ready),
        .o_ld_addr   (o_ld_addr),
        .o_ld_tag    (o_ld_tag),
        .o_ld_size   (o_ld_size),
        .o_exc_valid (o_exc_valid),
        .o_exc_tag   (o_exc_tag),
        .o_exc_addr  (o_exc_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t model(input logic [31:0] b, input logic [31:0] imm,
                                   input logic [W-1:0] t, input logic st, input logic [1:0] sz);
        exp_t e;
        logic mis;
        e.addr = b + imm;
        mis = (sz == 2'b11) || (sz == 2'b01 && e.addr[0]) || (sz == 2'b10 && e.addr[1:0] != 2'b00);
        e.kind = mis ? 2 : (st ? 0 : 1);
        e.tag  = t;
        e.size = sz;
        return e;
    endfunction

    // Monitor: pops one expected entry for every output event, and checks held-load stability.
    logic          hold_v = 1'b0;
    logic [31:0]   hold_addr;
    logic [W-1:0]  hold_tag;
    logic [1:0]    hold_size;

    always @(negedge clk) begin
        exp_t e;
        int kind;
        logic [31:0] a_addr;
        logic [W-1:0] a_tag;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (o_ld_valid !== 1'b1 || o_ld_addr !== hold_addr || o_ld_tag !== hold_tag || o_ld_size !== hold_size) begin
                    errors++;
                    $display("FAIL ld_stable: got v=%b addr=%h tag=%0d size=%0d, expected v=1 addr=%h tag=%0d size=%0d",
                             o_ld_valid, o_ld_addr, o_ld_tag, o_ld_size, hold_addr, hold_tag, hold_size);
                end
            end
            hold_v = 1'b0;
            kind = -1;
            a_addr = '0;
            a_tag = '0;
            if (o_saq_en === 1'b1) begin kind = 0; a_addr = o_saq_addr; a_tag = o_saq_tag; end
            else if (o_ld_valid === 1'b1 && i_ld_ready) begin kind = 1; a_addr = o_ld_addr; a_tag = o_ld_tag; end
            else if (o_exc_valid === 1'b1) begin kind = 2; a_addr = o_exc_addr; a_tag = o_exc_tag; end
            if (kind >= 0) begin
                checks++;
                if ((o_saq_en + o_ld_valid + o_exc_valid) > 1) begin
                    errors++;
                    $display("FAIL one_hot: got saq=%b ld=%b exc=%b, expected at most one", o_saq_en, o_ld_valid, o_exc_valid);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got kind=%0d addr=%h tag=%0d, expected none", kind, a_addr, a_tag);
                end else begin
                    e = sb.pop_front();
                    if (kind != e.kind || a_addr !== e.addr || a_tag !== e.tag || (kind == 1 && o_ld_size !== e.size)) begin
                        errors++;
                        $display("FAIL scoreboard: got kind=%0d addr=%h tag=%0d size=%0d, expected kind=%0d addr=%h tag=%0d size=%0d",
                                 kind, a_addr, a_tag, o_ld_size, e.kind, e.addr, e.tag, e.size);
                    end
                end
            end
            if (o_ld_valid === 1'b1 && !i_ld_ready && !i_flush) begin
                hold_v = 1'b1;
                hold_addr = o_ld_addr;
                hold_tag = o_ld_tag;
                hold_size = o_ld_size;
            end
        end
    end

    // Drives one op starting just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] b, input logic [31:0] imm, input logic [W-1:0] t,
                         input logic st, input logic [1:0] sz);
        int unsigned n = 0;
        i_valid = 1'b1; i_base = b; i_imm = imm; i_tag = t; i_store = st; i_size = sz;
        @(negedge clk);
        while (o_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_accept: got o_ready=%b after %0d cycles, expected 1", o_ready, n);
        end else begin
            sb.push_back(model(b, imm, t, st, sz));
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_base = '0; i_imm = '0; i_tag = '0;
        i_store = 1'b0; i_size = '0; i_flush = 1'b0; i_ld_ready = 1'b1;
        #2;
        checks++;
        if ({o_saq_en, o_saq_addr, o_saq_tag, o_ld_valid, o_ld_addr, o_ld_tag, o_ld_size,
             o_exc_valid, o_exc_tag, o_exc_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got saq=%b ld=%b exc=%b addr=%h, expected all 0", o_saq_en, o_ld_valid, o_exc_valid, o_ld_addr);
        end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", o_ready); end
        i_flush = 1'b1; #1;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_flush: got %b, expected 0", o_ready); end
        i_flush = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        issue(32'h0000_1000, 32'h0000_0024, 5'd3, 1'b1, 2'b10);
        @(negedge clk);
        checks++;
        if (o_saq_en !== 1'b0) begin errors++; $display("FAIL store_early: got saq_en=%b, expected 0", o_saq_en); end
        @(negedge clk);
        checks++;
        if (o_saq_en !== 1'b1 || o_saq_addr !== 32'h0000_1024 || o_saq_tag !== 5'd3) begin
            errors++;
            $display("FAIL store_out: got en=%b addr=%h tag=%0d, expected en=1 addr=00001024 tag=3", o_saq_en, o_saq_addr, o_saq_tag);
        end
        @(negedge clk);
        checks++;
        if (o_saq_en !== 1'b0) begin errors++; $display("FAIL store_pulse: got saq_en=%b, expected 0", o_saq_en); end
        wait_drain();
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        issue(32'hFFFF_FFFC, 32'h0000_0008, 5'd5, 1'b0, 2'b10);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_ld_valid !== 1'b1 || o_ld_addr !== 32'h0000_0004 || o_exc_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load: got v=%b addr=%h exc=%b, expected v=1 addr=00000004 exc=0", o_ld_valid, o_ld_addr, o_exc_valid);
        end
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        i_ld_ready = 1'b0;
        issue(32'h0000_0100, 32'h0000_0010, 5'd10, 1'b0, 2'b10);
        fork
            begin
                issue(32'h0000_0200, 32'h0000_0004, 5'd11, 1'b0, 2'b01);
                issue(32'h0000_0300, 32'h0000_0001, 5'd12, 1'b1, 2'b00);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (o_ready !== 1'b0 || o_ld_valid !== 1'b1 || o_ld_addr !== 32'h0000_0110) begin
                    errors++;
                    $display("FAIL stall_state: got ready=%b ld_v=%b addr=%h, expected ready=0 ld_v=1 addr=00000110", o_ready, o_ld_valid, o_ld_addr);
                end
                repeat (2) @(posedge clk);
                #1 i_ld_ready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_misalign();
        int saq_seen = 0;
        int exc_seen = 0;
        @(posedge clk); #1;
        issue(32'h0000_1000, 32'h0000_0001, 5'd7, 1'b1, 2'b01);
        issue(32'h0000_2000, 32'h0000_0002, 5'd8, 1'b0, 2'b10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_saq_en === 1'b1) saq_seen++;
            if (o_exc_valid === 1'b1) exc_seen++;
        end
        checks++;
        if (saq_seen != 0) begin errors++; $display("FAIL misalign_saq: got %0d SAQ writes, expected 0", saq_seen); end
        checks++;
        if (exc_seen != 2) begin errors++; $display("FAIL misalign_exc: got %0d exceptions, expected 2", exc_seen); end
    endtask

    task automatic test_size_edges();
        @(posedge clk); #1;
        issue(32'h0000_0000, 32'h0000_0003, 5'd13, 1'b1, 2'b00);
        issue(32'h0000_0000, 32'h0000_0002, 5'd14, 1'b0, 2'b01);
        issue(32'h0000_0100, 32'h0000_0000, 5'd15, 1'b0, 2'b11);
        issue(32'h0000_0010, 32'hFFFF_FFF0, 5'd16, 1'b1, 2'b10);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 5'd17, 1'b1, 2'b01);
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL size_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        time t0;
        @(posedge clk); #1;
        t0 = $time;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] b;
            b = $urandom & 32'hFFFF_FFFC;
            issue(b, 32'h0000_0004 * i, W'(20 + i), i[0], 2'b10);
        end
        checks++;
        if ($time - t0 != 60) begin errors++; $display("FAIL b2b_rate: got %0t ns for 6 ops, expected 60", $time - t0); end
        wait_drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_flush();
        int seen = 0;
        @(posedge clk); #1;
        sb.push_back(model(32'h0000_4000, 32'h0000_0008, 5'd1, 1'b1, 2'b10));
        i_valid = 1'b1; i_base = 32'h0000_4000; i_imm = 32'h8; i_tag = 5'd1; i_store = 1'b1; i_size = 2'b10;
        @(posedge clk); #1;
        i_base = 32'h0000_5000; i_tag = 5'd2;
        @(posedge clk); #1;
        i_base = 32'h0000_6000; i_tag = 5'd4; i_flush = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_saq_en !== 1'b1 || o_saq_tag !== 5'd1) begin
            errors++;
            $display("FAIL flush_cycle: got ready=%b saq=%b tag=%0d, expected ready=0 saq=1 tag=1", o_ready, o_saq_en, o_saq_tag);
        end
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_saq_en === 1'b1 || o_ld_valid === 1'b1 || o_exc_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_kill: got %0d output cycles, expected 0", seen); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL flush_drain: got %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_reset_stall();
        @(posedge clk); #1;
        i_ld_ready = 1'b0;
        issue(32'h0000_7000, 32'h0, 5'd21, 1'b0, 2'b10);
        issue(32'h0000_7100, 32'h0, 5'd22, 1'b0, 2'b10);
        @(negedge clk);
        checks++;
        if (o_ld_valid !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_stall: got ld_v=%b ready=%b, expected ld_v=1 ready=0", o_ld_valid, o_ready);
        end
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({o_saq_en, o_saq_addr, o_saq_tag, o_ld_valid, o_ld_addr, o_ld_tag, o_ld_size,
             o_exc_valid, o_exc_tag, o_exc_addr} !== '0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got saq=%b ld=%b exc=%b addr=%h ready=%b, expected all 0 ready=1",
                     o_saq_en, o_ld_valid, o_exc_valid, o_ld_addr, o_ready);
        end
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        i_ld_ready = 1'b1;
        @(posedge clk); #1;
        issue(32'h0000_8000, 32'h0000_000C, 5'd9, 1'b1, 2'b10);
        @(negedge clk);
        checks++;
        if (o_saq_en !== 1'b0 || o_ld_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_early: got saq=%b ld=%b, expected 0 0", o_saq_en, o_ld_valid);
        end
        @(negedge clk);
        checks++;
        if (o_saq_en !== 1'b1 || o_saq_addr !== 32'h0000_800C || o_saq_tag !== 5'd9) begin
            errors++;
            $display("FAIL rst_after_store: got en=%b addr=%h tag=%0d, expected en=1 addr=0000800c tag=9", o_saq_en, o_saq_addr, o_saq_tag);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_store();
        test_wrap();
        test_stall();
        test_misalign();
        test_size_edges();
        test_back_to_back();
        test_flush();
        test_reset_stall();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_drain: got %0d pending, expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
